// File: rtl/opti_coeff_loader.sv
// Biquad coefficient loader: walks the coefficient ROM one section at a time,
// gathers the five words (b0,b1,b2,a1,a2) into registers and offers each set
// to the IIR cascade through a valid/ready handshake, then pulses done.
module opti_coeff_loader #(
   parameter int unsigned N_SECT = 4,
   parameter int unsigned COEF_W = 24,
   parameter int unsigned ADDR_W = 5,
   localparam int unsigned SECT_W = (N_SECT > 1) ? $clog2(N_SECT) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic [ADDR_W-1:0]        coef_addr,
   input  logic [COEF_W-1:0]        coef_data,
   output logic [SECT_W-1:0]        sect_idx,
   output logic signed [COEF_W-1:0] b0,
   output logic signed [COEF_W-1:0] b1,
   output logic signed [COEF_W-1:0] b2,
   output logic signed [COEF_W-1:0] a1,
   output logic signed [COEF_W-1:0] a2,
   output logic                     sect_valid,
   input  logic                     sect_ready,
   output logic                     done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_PRESENT,
      S_DONE
   } state_t;

   localparam logic [SECT_W-1:0] LAST_SECT = SECT_W'(N_SECT - 1);

   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SECT_W-1:0] sect_q, sect_d;
   logic [2:0]        k_q, k_d;
   logic [COEF_W-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;

   logic handshake;
   logic last_slot;

   assign handshake = (state_q == S_PRESENT) && sect_ready;
   assign last_slot = (k_q == 3'd4);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_FETCH;
         S_FETCH:   if (last_slot) state_d = S_PRESENT;
         S_PRESENT: if (handshake) state_d = (sect_q == LAST_SECT) ? S_DONE : S_FETCH;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Status outputs decoded from the current state
   always_comb begin
      busy       = (state_q != S_IDLE);
      sect_valid = (state_q == S_PRESENT);
      done       = (state_q == S_DONE);
   end

   // Datapath next values: address walk, slot counter, section index, slot capture
   always_comb begin
      addr_d = addr_q;
      sect_d = sect_q;
      k_d    = k_q;
      b0_d   = b0_q;
      b1_d   = b1_q;
      b2_d   = b2_q;
      a1_d   = a1_q;
      a2_d   = a2_q;
      case (state_q)
         S_IDLE: begin
            addr_d = '0;
            if (start) begin
               sect_d = '0;
               k_d    = '0;
            end
         end
         S_FETCH: begin
            case (k_q)
               3'd0:    b0_d = coef_data;
               3'd1:    b1_d = coef_data;
               3'd2:    b2_d = coef_data;
               3'd3:    a1_d = coef_data;
               default: a2_d = coef_data;
            endcase
            // Address stays on the section's last word while presenting, so the
            // step to the next section is a plain increment from PRESENT.
            if (last_slot) begin
               k_d = '0;
            end else begin
               k_d    = k_q + 3'd1;
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         S_PRESENT: begin
            if (handshake && (sect_q != LAST_SECT)) begin
               sect_d = sect_q + SECT_W'(1);
               k_d    = '0;
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         S_DONE: begin
            addr_d = '0;
         end
         default: begin
            addr_d = '0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         sect_q <= '0;
         k_q    <= '0;
         b0_q   <= '0;
         b1_q   <= '0;
         b2_q   <= '0;
         a1_q   <= '0;
         a2_q   <= '0;
      end else begin
         addr_q <= addr_d;
         sect_q <= sect_d;
         k_q    <= k_d;
         b0_q   <= b0_d;
         b1_q   <= b1_d;
         b2_q   <= b2_d;
         a1_q   <= a1_d;
         a2_q   <= a2_d;
      end
   end

   assign coef_addr = addr_q;
   assign sect_idx  = sect_q;
   assign b0        = b0_q;
   assign b1        = b1_q;
   assign b2        = b2_q;
   assign a1        = a1_q;
   assign a2        = a2_q;

endmodule

// File: tb/tb_opti_coeff_loader.sv
// Testbench for opti_coeff_loader: ROM model, scoreboard of expected sections,
// negedge monitor, directed plus randomized handshake scenarios.
module tb_opti_coeff_loader;

   localparam int unsigned COEF_W = 24;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NS     = 4;

   typedef struct {
      int unsigned       idx;
      logic [4:0][23:0]  c;
   } sect_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [23:0] rom [0:19];

   // DUT with four sections
   logic                     start, busy, sect_valid, sect_ready, done;
   logic [ADDR_W-1:0]        coef_addr;
   logic [COEF_W-1:0]        coef_data;
   logic [1:0]               sect_idx;
   logic signed [COEF_W-1:0] b0, b1, b2, a1, a2;

   assign coef_data = (coef_addr < 5'd20) ? rom[coef_addr] : 24'h0;

   opti_coeff_loader #(.N_SECT(4), .COEF_W(24), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
      .coef_addr(coef_addr), .coef_data(coef_data), .sect_idx(sect_idx),
      .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
      .sect_valid(sect_valid), .sect_ready(sect_ready), .done(done)
   );

   // DUT with a single section
   logic                     start1, busy1, sect_valid1, sect_ready1, done1;
   logic [ADDR_W-1:0]        coef_addr1;
   logic [COEF_W-1:0]        coef_data1;
   logic [0:0]               sect_idx1;
   logic signed [COEF_W-1:0] b0_1, b1_1, b2_1, a1_1, a2_1;

   assign coef_data1 = (coef_addr1 < 5'd20) ? rom[coef_addr1] : 24'h0;

   opti_coeff_loader #(.N_SECT(1), .COEF_W(24), .ADDR_W(5)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
      .coef_addr(coef_addr1), .coef_data(coef_data1), .sect_idx(sect_idx1),
      .b0(b0_1), .b1(b1_1), .b2(b2_1), .a1(a1_1), .a2(a2_1),
      .sect_valid(sect_valid1), .sect_ready(sect_ready1), .done(done1)
   );

   int    checks = 0;
   int    errors = 0;
   sect_t exp_q[$];
   int    done_exp = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Expected response of one complete load: every section in ROM order, then one done
   task automatic push_load();
      sect_t s;
      for (int unsigned i = 0; i < NS; i++) begin
         s.idx = i;
         for (int unsigned j = 0; j < 5; j++) s.c[j] = rom[5*i + j];
         exp_q.push_back(s);
      end
      done_exp++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input bit rand_ready);
      int n = 0;
      while (!done && n < 400) begin
         if (rand_ready) sect_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      chk("done_timeout", {63'd0, done}, 64'd1);
      sect_ready = 1'b1;
   endtask

   // Monitor: compare presented sections against the scoreboard
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("addr_range", {63'd0, (coef_addr <= 5'd19)}, 64'd1);
         if (sect_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_section: got idx %0d expected none", sect_idx);
            end else begin
               chk("sect_idx", 64'(sect_idx), 64'(exp_q[0].idx));
               chk("b0", 64'($unsigned(b0)), 64'(exp_q[0].c[0]));
               chk("b1", 64'($unsigned(b1)), 64'(exp_q[0].c[1]));
               chk("b2", 64'($unsigned(b2)), 64'(exp_q[0].c[2]));
               chk("a1", 64'($unsigned(a1)), 64'(exp_q[0].c[3]));
               chk("a2", 64'($unsigned(a2)), 64'(exp_q[0].c[4]));
               if (!sect_ready) chk("stall_addr", 64'(coef_addr), 64'(5*exp_q[0].idx + 4));
               else void'(exp_q.pop_front());
            end
         end
         if (done) begin
            if (done_exp == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
            end else begin
               done_exp--;
            end
         end
      end
   end

   initial begin
      logic [4:0] ea;
      int n;

      foreach (rom[i]) rom[i] = 24'($urandom);
      rom[0]  = 24'h25EA25; rom[1]  = 24'h4B38E9; rom[2]  = 24'h25EA25;
      rom[3]  = 24'h32FD14; rom[4]  = 24'h0AD744;
      rom[5]  = 24'h25EA25; rom[6]  = 24'h470B14; rom[7]  = 24'h25EA25;
      rom[8]  = 24'h33BC62; rom[9]  = 24'h109A47;
      rom[18] = 24'h3EB56E; rom[19] = 24'h31375C;
      rom[12] = 24'hC0FFEE; // negative word checks no sign handling in the path

      start = 1'b0; sect_ready = 1'b0; start1 = 1'b0; sect_ready1 = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("rst_busy",  {63'd0, busy}, 64'd0);
      chk("rst_valid", {63'd0, sect_valid}, 64'd0);
      chk("rst_done",  {63'd0, done}, 64'd0);
      chk("rst_addr",  64'(coef_addr), 64'd0);
      chk("rst_idx",   64'(sect_idx), 64'd0);
      chk("rst_b0",    64'($unsigned(b0)), 64'd0);
      chk("rst_a2",    64'($unsigned(a2)), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Full load with ready high: address trace and latency
      sect_ready = 1'b1;
      push_load();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int unsigned i = 0; i < 25; i++) begin
         if (i < 24) ea = 5'(5*(i/6) + ((i%6) > 4 ? 4 : (i%6)));
         else ea = 5'd19;
         chk("addr_trace", 64'(coef_addr), 64'(ea));
         chk("busy_run", {63'd0, busy}, 64'd1);
         chk("done_timing", {63'd0, done}, (i == 24) ? 64'd1 : 64'd0);
         tick();
      end
      chk("busy_after", {63'd0, busy}, 64'd0);
      chk("idle_addr", 64'(coef_addr), 64'd0);
      chk("retain_a1", 64'($unsigned(a1)), 64'h3EB56E);
      chk("retain_a2", 64'($unsigned(a2)), 64'h31375C);

      // Stall on section 1
      push_load();
      pulse_start();
      n = 0;
      while (!(sect_valid && sect_idx == 2'd1) && n < 100) begin tick(); n++; end
      chk("reach_sect1", {63'd0, (sect_valid && sect_idx == 2'd1)}, 64'd1);
      sect_ready = 1'b0;
      for (int unsigned i = 0; i < 10; i++) begin
         tick();
         chk("stall_valid", {63'd0, sect_valid}, 64'd1);
         chk("stall_b1", 64'($unsigned(b1)), 64'h470B14);
         chk("stall_a1", 64'($unsigned(a1)), 64'h33BC62);
         chk("stall_a2", 64'($unsigned(a2)), 64'h109A47);
         chk("stall_addr9", 64'(coef_addr), 64'd9);
      end
      wait_done(1'b1);
      tick(); tick();

      // Randomized ready on several loads
      for (int unsigned r = 0; r < 3; r++) begin
         push_load();
         pulse_start();
         wait_done(1'b1);
         tick();
      end

      // start during FETCH and DONE is ignored
      push_load();
      pulse_start();
      tick();
      pulse_start();
      wait_done(1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         chk("no_restart", {63'd0, busy}, 64'd0);
         tick();
      end

      // start held high: back-to-back loads from address 0
      push_load();
      push_load();
      start = 1'b1;
      tick();
      wait_done(1'b0);
      tick();
      chk("held_idle", {63'd0, busy}, 64'd0);
      tick();
      chk("held_restart", {63'd0, busy}, 64'd1);
      chk("held_addr0", 64'(coef_addr), 64'd0);
      start = 1'b0;
      wait_done(1'b0);
      tick(); tick();
      chk("held_stop", {63'd0, busy}, 64'd0);

      // Asynchronous reset while fetching section 2, slot 3
      push_load();
      pulse_start();
      n = 0;
      while (!(sect_idx == 2'd2 && !sect_valid && coef_addr == 5'd13) && n < 100) begin tick(); n++; end
      chk("reach_s2k3", 64'(coef_addr), 64'd13);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_busy",  {63'd0, busy}, 64'd0);
      chk("mid_addr",  64'(coef_addr), 64'd0);
      chk("mid_idx",   64'(sect_idx), 64'd0);
      chk("mid_b0",    64'($unsigned(b0)), 64'd0);
      chk("mid_a1",    64'($unsigned(a1)), 64'd0);
      chk("mid_valid", {63'd0, sect_valid}, 64'd0);
      exp_q.delete();
      done_exp = 0;
      tick();
      rst_n = 1'b1;
      tick();
      push_load();
      pulse_start();
      wait_done(1'b1);
      tick(); tick();

      // Single-section instance
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int unsigned i = 0; i < 7; i++) begin
         chk("s1_addr", 64'(coef_addr1), (i < 6) ? 64'((i > 4) ? 4 : i) : 64'd4);
         chk("s1_done", {63'd0, done1}, (i == 6) ? 64'd1 : 64'd0);
         chk("s1_valid", {63'd0, sect_valid1}, (i == 5) ? 64'd1 : 64'd0);
         if (i == 5) begin
            chk("s1_b0", 64'($unsigned(b0_1)), 64'h25EA25);
            chk("s1_b1", 64'($unsigned(b1_1)), 64'h4B38E9);
            chk("s1_a2", 64'($unsigned(a2_1)), 64'h0AD744);
         end
         tick();
      end
      chk("s1_busy_after", {63'd0, busy1}, 64'd0);

      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      chk("done_all", 64'(done_exp), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

endmodule
